wb_regfile: RTL
===============

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter CPU_WIDTH, default 16, data width of results and registers.
REQ-002 Parameter REG_ADDR_W, default 3, register index width (2**REG_ADDR_W registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  execute stage presents an ALU result.
REQ-006 in_ready  output  1  block accepts the result this cycle.
REQ-007 in_rd  input  REG_ADDR_W  destination register.
REQ-008 in_wen  input  1  result is to be written (0 = discard, e.g. compare/no-write op).
REQ-009 in_result  input  CPU_WIDTH  ALU output value.
REQ-010 in_ovf  input  1  ALU overflow flag for this result.
REQ-011 trap_en  input  1  overflow suppresses the write when set.
REQ-012 ld_valid / ld_rd / ld_data  input  1 / REG_ADDR_W / CPU_WIDTH  load-return write request; always accepted.
REQ-013 ra_addr, rb_addr  input  REG_ADDR_W  operand read addresses feeding ALU A and B.
REQ-014 ra_data, rb_data  output  CPU_WIDTH  operand read data, combinational.
REQ-015 ovf_flag  output  1  sticky overflow status; ovf_clr input 1 clears it.
REQ-016 ovf_pulse  output  1  one-cycle pulse when a trapped overflow retires.

Function
REQ-017 One writeback register (wb_valid, wb_rd, wb_wen, wb_data, wb_ovf) SHALL capture the input when in_valid && in_ready.
REQ-018 in_ready SHALL equal !wb_valid || !ld_valid (the slot is free, or it drains this cycle).
REQ-019 Array write port: ld_valid has priority; otherwise a valid wb entry retires (writes if wb_wen && !(wb_ovf && trap_en_latched)) and wb_valid clears unless refilled the same cycle.
REQ-020 trap_en SHALL be sampled into the wb register with the result; the latched copy governs suppression.
REQ-021 Latency: result accepted in cycle N SHALL be in the array after edge N+1 when no load collides; each colliding load adds one cycle.
REQ-022 Register 0 SHALL read as zero and writes to it SHALL be ignored (both paths).
REQ-023 Read bypass priority for a nonzero address: ld_data if ld_valid && ld_rd matches; else wb_data if wb_valid && wb_wen && !suppressed && wb_rd matches; else array.
REQ-024 Load and pending wb to the same register: load writes first, wb writes next cycle; final value SHALL be the wb result.
REQ-025 ovf_pulse SHALL assert in the retiring cycle of a suppressed entry; ovf_flag SHALL set on that edge.
REQ-026 ovf_flag set and ovf_clr in the same cycle: set SHALL win.
REQ-027 in_wen=0 entries SHALL occupy the slot and retire without writing or raising overflow.

Reset
REQ-028 rst SHALL clear wb_valid, ovf_flag, ovf_pulse and all array registers to 0; in_ready SHALL read 1 in the first cycle after reset.
REQ-029 rst asserted mid-operation SHALL discard any pending wb entry and any same-cycle load write.

Structure
REQ-030 CPU_WIDTH, REG_ADDR_W defaults and the R0 index constant SHALL live in the shared para include alongside the ALU op codes.
REQ-031 The register array with bypass-free read ports SHALL be one sub-module, regfile_array; the writeback slot, arbitration and bypass SHALL live in wb_regfile.

Verification
REQ-032 Write R3=0x1234 via in_* -> ra_addr=3 reads 0x1234 in the cycle after acceptance (bypass) and from the array one cycle later.
REQ-033 ld_valid to R5=0xAAAA while wb entry R5=0x5555 pending -> in_ready=0 that cycle; R5 ends 0x5555 after two edges.
REQ-034 in_ovf=1, trap_en=1, R2=0x7FFF target -> R2 unchanged, ovf_pulse high one cycle, ovf_flag=1 until ovf_clr.
REQ-035 Write R0=0xFFFF from both paths -> ra_addr=0 and rb_addr=0 read 0x0000.
REQ-036 Back-to-back results R1=1, R1=2, R1=3 with no loads -> in_ready stays 1, R1 reads 3; trapped overflow with ovf_clr same cycle -> ovf_flag=1.
REQ-037 rst asserted with wb entry R4=0x00FF pending -> R4 reads 0, wb_valid=0, ovf_flag=0 after the edge.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared parameters for the writeback / register-file slice.
// Holds the width defaults, the hard-wired zero register index and the ALU op codes.
package wb_regfile_pkg;

    localparam int CPU_WIDTH_DEF  = 16;
    localparam int REG_ADDR_W_DEF = 3;

    // Register index that always reads zero and ignores writes.
    localparam int R0_IDX = 0;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SHL = 3'd5,
        ALU_SHR = 3'd6,
        ALU_CMP = 3'd7
    } alu_op_e;

endpackage

// File: rtl/wb_regfile_array.sv
// Register storage with one write port and two bypass-free read ports.
// Index R0 reads as zero and ignores writes.
module regfile_array
    import wb_regfile_pkg::*;
#(
    parameter int CPU_WIDTH  = CPU_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [CPU_WIDTH-1:0]  wdata,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [CPU_WIDTH-1:0]  ra_data,
    output logic [CPU_WIDTH-1:0]  rb_data
);

    localparam int                  NREG = 2 ** REG_ADDR_W;
    localparam logic [REG_ADDR_W-1:0] R0 = REG_ADDR_W'(R0_IDX);

    logic [CPU_WIDTH-1:0] regs [NREG];

    // Storage update: reset clears everything, R0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else if (we && (waddr != R0)) begin
            regs[waddr] <= wdata;
        end
    end

    assign ra_data = (ra_addr == R0) ? '0 : regs[ra_addr];
    assign rb_data = (rb_addr == R0) ? '0 : regs[rb_addr];

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage: single result slot, load-over-writeback arbitration for the
// array write port, operand read bypass and sticky overflow status.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int CPU_WIDTH  = CPU_WIDTH_DEF,
    parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_wen,
    input  logic [CPU_WIDTH-1:0]  in_result,
    input  logic                  in_ovf,
    input  logic                  trap_en,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [CPU_WIDTH-1:0]  ld_data,
    input  logic [REG_ADDR_W-1:0] ra_addr,
    input  logic [REG_ADDR_W-1:0] rb_addr,
    output logic [CPU_WIDTH-1:0]  ra_data,
    output logic [CPU_WIDTH-1:0]  rb_data,
    output logic                  ovf_flag,
    input  logic                  ovf_clr,
    output logic                  ovf_pulse
);

    localparam logic [REG_ADDR_W-1:0] R0 = REG_ADDR_W'(R0_IDX);

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_wen;
    logic [CPU_WIDTH-1:0]  wb_data;
    logic                  wb_ovf;
    logic                  wb_trap;

    logic                  accept;
    logic                  retire;
    logic                  wb_sup;
    logic                  wb_live;
    logic                  arr_we;
    logic [REG_ADDR_W-1:0] arr_waddr;
    logic [CPU_WIDTH-1:0]  arr_wdata;
    logic [CPU_WIDTH-1:0]  arr_ra;
    logic [CPU_WIDTH-1:0]  arr_rb;

    // A load always owns the write port, so the slot only drains on load-free cycles.
    assign in_ready = !wb_valid || !ld_valid;
    assign accept   = in_valid && in_ready;
    assign retire   = wb_valid && !ld_valid;
    // Suppression uses the trap enable captured with the result, not the live input.
    assign wb_sup   = wb_ovf && wb_trap;
    assign wb_live  = wb_valid && wb_wen && !wb_sup;

    assign ovf_pulse = !rst && retire && wb_wen && wb_sup;

    // Writeback slot: refill on accept, otherwise empty out when it retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_valid <= 1'b0;
        end else if (accept) begin
            wb_valid <= 1'b1;
        end else if (retire) begin
            wb_valid <= 1'b0;
        end
    end

    // Slot payload; no reset needed since wb_valid qualifies every use.
    always_ff @(posedge clk) begin
        if (accept) begin
            wb_rd   <= in_rd;
            wb_wen  <= in_wen;
            wb_data <= in_result;
            wb_ovf  <= in_ovf;
            wb_trap <= trap_en;
        end
    end

    // Sticky overflow: a retiring trapped overflow beats a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag <= 1'b0;
        end else if (ovf_pulse) begin
            ovf_flag <= 1'b1;
        end else if (ovf_clr) begin
            ovf_flag <= 1'b0;
        end
    end

    // Write-port arbitration: load first, else a retiring unsuppressed result.
    always_comb begin
        arr_we    = 1'b0;
        arr_waddr = ld_rd;
        arr_wdata = ld_data;
        if (ld_valid) begin
            arr_we = 1'b1;
        end else if (retire && wb_live) begin
            arr_we    = 1'b1;
            arr_waddr = wb_rd;
            arr_wdata = wb_data;
        end
    end

    regfile_array #(
        .CPU_WIDTH (CPU_WIDTH),
        .REG_ADDR_W(REG_ADDR_W)
    ) u_array (
        .clk    (clk),
        .rst    (rst),
        .we     (arr_we),
        .waddr  (arr_waddr),
        .wdata  (arr_wdata),
        .ra_addr(ra_addr),
        .rb_addr(rb_addr),
        .ra_data(arr_ra),
        .rb_data(arr_rb)
    );

    // Newest value wins: in-flight load, then pending result, then storage.
    function automatic logic [CPU_WIDTH-1:0] bypass(
        input logic [REG_ADDR_W-1:0] a,
        input logic [CPU_WIDTH-1:0]  arr
    );
        if (a == R0)                   return '0;
        if (ld_valid && ld_rd == a)    return ld_data;
        if (wb_live && wb_rd == a)     return wb_data;
        return arr;
    endfunction

    // Operand read ports with bypass.
    always_comb begin
        ra_data = bypass(ra_addr, arr_ra);
        rb_data = bypass(rb_addr, arr_rb);
    end

endmodule
